// File: rtl/envelope_follower.sv
// Envelope follower with attack/release smoothing and a hysteretic noise gate.
// The envelope, gate and sample outputs all appear one cycle after the strobe.
module envelope_follower #(
    parameter int OPEN_TH      = 2048,
    parameter int CLOSE_TH     = 1024,
    parameter int HOLD_SAMPLES = 4800
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [2:0]         i_attack,
    input  logic [2:0]         i_release,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic [15:0]        o_env,
    output logic               o_gate,
    output logic               o_valid
);

    localparam int CW = $clog2(HOLD_SAMPLES + 1);

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nx;
    logic [15:0]         r_env;
    logic [15:0]         w_env_nx;
    logic [15:0]         w_env_upd;
    logic [15:0]         w_mag;
    logic [15:0]         w_up;
    logic [15:0]         w_dn;
    logic [15:0]         w_da;
    logic [15:0]         w_dr;
    logic signed [15:0]  r_data;
    logic                r_valid;

    // -32768 has no positive counterpart, so it clips to full scale
    always_comb begin
        if (i_data == 16'sh8000) begin
            w_mag = 16'h7fff;
        end else if (i_data[15]) begin
            w_mag = ~i_data + 16'd1;
        end else begin
            w_mag = i_data;
        end
    end

    assign w_up = w_mag - r_env;
    assign w_dn = r_env - w_mag;
    assign w_da = w_up >> i_attack;
    assign w_dr = w_dn >> i_release;

    always_comb begin
        w_env_upd = r_env;
        if (w_mag > r_env) begin
            w_env_upd = r_env + ((w_da == 16'd0) ? 16'd1 : w_da);
        end else if (w_mag < r_env) begin
            w_env_upd = r_env - ((w_dr == 16'd0) ? 16'd1 : w_dr);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_env_nx   = r_env;
        if (!i_enable) begin
            w_state_nx = CLOSED;
            w_cnt_nx   = '0;
            w_env_nx   = 16'd0;
        end else if (i_valid) begin
            w_env_nx = w_env_upd;
            case (r_state)
                CLOSED: begin
                    if (w_env_upd >= 16'(OPEN_TH)) w_state_nx = OPEN;
                end
                OPEN: begin
                    if (w_env_upd < 16'(CLOSE_TH)) begin
                        w_state_nx = HOLD;
                        w_cnt_nx   = '0;
                    end
                end
                HOLD: begin
                    if (w_env_upd >= 16'(OPEN_TH)) begin
                        w_state_nx = OPEN;
                    end else if (r_cnt == CW'(HOLD_SAMPLES - 1)) begin
                        w_state_nx = CLOSED;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                default: w_state_nx = CLOSED;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLOSED;
            r_cnt   <= '0;
            r_env   <= 16'd0;
            r_data  <= 16'sd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_env   <= w_env_nx;
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

    assign o_data  = r_data;
    assign o_env   = r_env;
    assign o_gate  = (r_state != CLOSED);
    assign o_valid = r_valid;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower with a queue of expected outputs
// checked whenever o_valid appears.
module tb_envelope_follower;

    logic               clk = 1'b0;
    logic               rst;
    logic               vld;
    logic               en;
    logic [2:0]         att;
    logic [2:0]         rel;
    logic signed [15:0] din;
    logic signed [15:0] o_data;
    logic [15:0]        o_env;
    logic               o_gate;
    logic               o_valid;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic signed [15:0] d;
        logic [15:0]        e;
        logic               g;
    } exp_t;

    exp_t q[$];

    envelope_follower #(
        .OPEN_TH(2048),
        .CLOSE_TH(1024),
        .HOLD_SAMPLES(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(vld),
        .i_enable(en),
        .i_attack(att),
        .i_release(rel),
        .i_data(din),
        .o_data(o_data),
        .o_env(o_env),
        .o_gate(o_gate),
        .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] d, input logic [15:0] e,
                        input logic g);
        exp_t x;
        @(negedge clk);
        vld = 1'b1;
        din = d;
        x.d = d;
        x.e = e;
        x.g = g;
        q.push_back(x);
        @(negedge clk);
        vld = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (o_valid === 1'b1) begin
            nvec++;
            assert (q.size() > 0) else begin
                nmis++;
                $error("FAIL unexpected_valid got 1 expected 0");
            end
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("data", 32'(o_data), 32'(x.d));
                chk("env", 32'(o_env), 32'(x.e));
                chk("gate", 32'(o_gate), 32'(x.g));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        vld = 1'b0;
        en  = 1'b1;
        att = 3'd0;
        rel = 3'd0;
        din = 16'sd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_env", 32'(o_env), 32'd0);
        chk("rst_gate", 32'(o_gate), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send(16'sd1000, 16'd1000, 1'b0);
        send(16'sd0, 16'd0, 1'b0);

        att = 3'd2;
        send(16'sd8000, 16'd2000, 1'b0);
        send(16'sd8000, 16'd3500, 1'b1);
        send(16'sd8000, 16'd4625, 1'b1);
        send(16'sd8000, 16'd5468, 1'b1);

        att = 3'd0;
        send(-16'sd32768, 16'd32767, 1'b1);
        send(-16'sd5000, 16'd5000, 1'b1);

        send(16'sd3000, 16'd3000, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b0);

        send(16'sd3000, 16'd3000, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd3000, 16'd3000, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b1);
        send(16'sd0, 16'd0, 1'b0);

        send(16'sd100, 16'd100, 1'b0);
        rel = 3'd7;
        send(16'sd0, 16'd99, 1'b0);
        send(16'sd0, 16'd98, 1'b0);
        send(16'sd0, 16'd97, 1'b0);

        rel = 3'd0;
        send(16'sd2047, 16'd2047, 1'b0);
        send(16'sd2048, 16'd2048, 1'b1);
        send(16'sd1024, 16'd1024, 1'b1);
        send(16'sd1023, 16'd1023, 1'b1);
        send(16'sd1500, 16'd1500, 1'b1);
        send(16'sd1500, 16'd1500, 1'b1);
        send(16'sd1500, 16'd1500, 1'b0);

        send(16'sd3000, 16'd3000, 1'b1);
        en = 1'b0;
        send(16'sd1234, 16'd0, 1'b0);
        en = 1'b1;
        send(16'sd600, 16'd600, 1'b0);

        send(16'sd3000, 16'd3000, 1'b1);
        send(16'sd900, 16'd900, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_env", 32'(o_env), 32'd0);
        chk("mid_rst_gate", 32'(o_gate), 32'd0);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(16'sd500, 16'd500, 1'b0);

        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
